// File: rtl/serial_fetch_engine_if.sv
// Request/response and serial memory-link signals of serial_fetch_engine.
// The master is the requester plus external memory; the slave is the engine.
interface serial_fetch_engine_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_ready;
    logic                  abort;
    logic                  addr_stream;
    logic                  data_stream;
    logic                  fetch_active;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_addr, abort, data_stream,
        input  req_ready, addr_stream, fetch_active, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, abort, data_stream,
        output req_ready, addr_stream, fetch_active, rsp_valid, rsp_data
    );
endinterface

// File: rtl/serial_fetch_engine.sv
// Serial fetch engine: shifts an address out bit by bit, waits a turnaround,
// shifts a data word in and presents it for one cycle with a fixed latency.
module serial_fetch_engine #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TURNAROUND = 1,
    parameter int LSB_FIRST  = 0
) (
    input  logic                   sys_clk,
    input  logic                   sys_reset_n,
    serial_fetch_engine_if.slave   bus
);
    localparam int ACW = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
    localparam int DCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int TCW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
    localparam logic [ACW-1:0] ADDR_LAST = ACW'(ADDR_WIDTH - 1);
    localparam logic [DCW-1:0] DATA_LAST = DCW'(DATA_WIDTH - 1);
    localparam logic [TCW-1:0] TURN_LAST = TCW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND_ADDR, S_TURN, S_RECV, S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [ACW-1:0]        r_addr_cnt;
    logic [TCW-1:0]        r_turn_cnt;
    logic [DCW-1:0]        r_data_cnt;
    logic                  w_accept;
    logic                  w_addr_bit;
    logic [ADDR_WIDTH-1:0] w_addr_shift;
    logic [DATA_WIDTH-1:0] w_shift_in;

    // The address register shifts so the outgoing bit always sits at one fixed end.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_addr_bit   = r_addr[0];
            assign w_addr_shift = {1'b0, r_addr[ADDR_WIDTH-1:1]};
            assign w_shift_in   = {bus.data_stream, r_shift[DATA_WIDTH-1:1]};
        end else begin : g_msb_first
            assign w_addr_bit   = r_addr[ADDR_WIDTH-1];
            assign w_addr_shift = {r_addr[ADDR_WIDTH-2:0], 1'b0};
            assign w_shift_in   = {r_shift[DATA_WIDTH-2:0], bus.data_stream};
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SEND_ADDR;
                end
            end
            S_SEND_ADDR: begin
                if (bus.abort)
                    w_state_next = S_IDLE;
                else if (r_addr_cnt == ADDR_LAST)
                    w_state_next = (TURNAROUND == 0) ? S_RECV : S_TURN;
            end
            S_TURN: begin
                if (bus.abort)
                    w_state_next = S_IDLE;
                else if (r_turn_cnt == TURN_LAST)
                    w_state_next = S_RECV;
            end
            S_RECV: begin
                if (bus.abort)
                    w_state_next = S_IDLE;
                else if (r_data_cnt == DATA_LAST)
                    w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Counters restart whenever their phase is left, so none can wrap within a phase.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_shift    <= '0;
            r_rsp_data <= '0;
            r_addr_cnt <= '0;
            r_turn_cnt <= '0;
            r_data_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr     <= bus.req_addr;
                        r_shift    <= '0;
                        r_addr_cnt <= '0;
                        r_turn_cnt <= '0;
                        r_data_cnt <= '0;
                    end
                end
                S_SEND_ADDR: begin
                    r_addr     <= w_addr_shift;
                    r_addr_cnt <= (w_state_next == S_SEND_ADDR) ? r_addr_cnt + ACW'(1) : '0;
                end
                S_TURN: begin
                    r_turn_cnt <= (w_state_next == S_TURN) ? r_turn_cnt + TCW'(1) : '0;
                end
                S_RECV: begin
                    r_shift    <= w_shift_in;
                    r_data_cnt <= (w_state_next == S_RECV) ? r_data_cnt + DCW'(1) : '0;
                    // Only a complete word ever reaches the output register.
                    if (w_state_next == S_DONE)
                        r_rsp_data <= w_shift_in;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready    = (r_state == S_IDLE);
    assign bus.addr_stream  = (r_state == S_SEND_ADDR) & w_addr_bit;
    assign bus.fetch_active = (r_state == S_SEND_ADDR) | (r_state == S_TURN) |
                              (r_state == S_RECV);
    assign bus.rsp_valid    = (r_state == S_DONE);
    assign bus.rsp_data     = r_rsp_data;
endmodule

// File: tb/tb_serial_fetch_engine.sv
// Directed bench for serial_fetch_engine: default, LSB-first/narrow and
// zero-turnaround configurations, abort, reset mid-fetch and back-to-back requests.
module tb_serial_fetch_engine;
    localparam int A_TOTAL = 8 + 1 + 32;
    localparam int B_TOTAL = 4 + 1 + 8;
    localparam int C_TOTAL = 8 + 0 + 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [31:0] a_prev = 32'h0;

    always #5 clk = ~clk;

    serial_fetch_engine_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) a_if();
    serial_fetch_engine_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8))  b_if();
    serial_fetch_engine_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8))  c_if();

    serial_fetch_engine #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TURNAROUND(1), .LSB_FIRST(0))
        u_dut_a (.sys_clk(clk), .sys_reset_n(rst_n), .bus(a_if));
    serial_fetch_engine #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TURNAROUND(1), .LSB_FIRST(1))
        u_dut_b (.sys_clk(clk), .sys_reset_n(rst_n), .bus(b_if));
    serial_fetch_engine #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TURNAROUND(0), .LSB_FIRST(0))
        u_dut_c (.sys_clk(clk), .sys_reset_n(rst_n), .bus(c_if));

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    // One full fetch on instance A. abort_at = cycle index (0 = first address cycle)
    // in which abort is raised, -1 for none. hold keeps req_valid high with alt_addr.
    task automatic fetch_a(input logic [7:0] addr, input logic [31:0] word,
                           input int abort_at, input bit hold, input logic [7:0] alt_addr,
                           input bit skip_wait, input string tag);
        logic        exp_addr, exp_act, exp_vld;
        logic [31:0] exp_data;
        if (!skip_wait) @(negedge clk);
        n_tests++;
        if (a_if.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready: got %b want 1", tag, a_if.req_ready);
        end
        a_if.req_valid = 1'b1;
        a_if.req_addr  = addr;
        for (int j = 0; j <= A_TOTAL; j++) begin
            @(negedge clk);
            if (j == 0) begin
                a_if.req_valid = hold;
                a_if.req_addr  = alt_addr;
            end
            exp_addr = 1'b0;
            if (j < 8) exp_addr = addr[7-j];
            exp_act  = (j < A_TOTAL);
            exp_vld  = (j == A_TOTAL);
            exp_data = exp_vld ? word : a_prev;
            n_tests += 4;
            if (a_if.addr_stream !== exp_addr) begin
                n_fail++;
                $display("FAIL %s addr_stream c%0d: got %b want %b", tag, j, a_if.addr_stream, exp_addr);
            end
            if (a_if.fetch_active !== exp_act) begin
                n_fail++;
                $display("FAIL %s fetch_active c%0d: got %b want %b", tag, j, a_if.fetch_active, exp_act);
            end
            if (a_if.rsp_valid !== exp_vld) begin
                n_fail++;
                $display("FAIL %s rsp_valid c%0d: got %b want %b", tag, j, a_if.rsp_valid, exp_vld);
            end
            if (a_if.rsp_data !== exp_data) begin
                n_fail++;
                $display("FAIL %s rsp_data c%0d: got %h want %h", tag, j, a_if.rsp_data, exp_data);
            end
            if (j == abort_at) begin
                if (j == A_TOTAL) a_prev = word;
                a_if.abort = 1'b1;
                @(negedge clk);
                a_if.abort = 1'b0;
                a_if.data_stream = 1'b0;
                n_tests += 4;
                if (a_if.req_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s abort ready: got %b want 1", tag, a_if.req_ready);
                end
                if (a_if.fetch_active !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s abort active: got %b want 0", tag, a_if.fetch_active);
                end
                if (a_if.rsp_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s abort rsp_valid: got %b want 0", tag, a_if.rsp_valid);
                end
                if (a_if.rsp_data !== a_prev) begin
                    n_fail++;
                    $display("FAIL %s abort rsp_data: got %h want %h", tag, a_if.rsp_data, a_prev);
                end
                $display("[TB] %s: addr %h aborted in cycle %0d", tag, addr, j);
                return;
            end
            a_if.data_stream = (j >= 9 && j < 9 + 32) ? word[31-(j-9)] : 1'b0;
        end
        a_prev = word;
        $display("[TB] %s: addr %h -> data %h", tag, addr, a_if.rsp_data);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_tests += 6;
        if (a_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset ready: got %b want 1", a_if.req_ready); end
        if (a_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset rsp_valid: got %b want 0", a_if.rsp_valid); end
        if (a_if.rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset rsp_data: got %h want 0", a_if.rsp_data); end
        if (a_if.addr_stream !== 1'b0) begin n_fail++; $display("FAIL reset addr_stream: got %b want 0", a_if.addr_stream); end
        if (a_if.fetch_active !== 1'b0) begin n_fail++; $display("FAIL reset active: got %b want 0", a_if.fetch_active); end
        if (b_if.req_ready !== 1'b1 || c_if.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset ready_bc: got %b%b want 11", b_if.req_ready, c_if.req_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset: checked outputs");
    endtask

    task automatic test_default_fetch();
        fetch_a(8'hA5, 32'hDEADBEEF, -1, 1'b0, 8'h00, 1'b0, "default");
        @(negedge clk);
        n_tests += 2;
        if (a_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL hold rsp_valid: got %b want 0", a_if.rsp_valid); end
        if (a_if.rsp_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hold rsp_data: got %h want deadbeef", a_if.rsp_data); end
    endtask

    task automatic test_lsb_first();
        logic [3:0] addr;
        logic [7:0] tbits;
        logic       exp_addr, exp_vld;
        addr  = 4'h3;
        tbits = 8'b1000_0001;  // tbits[k] is the k-th data bit in time
        @(negedge clk);
        b_if.req_valid = 1'b1;
        b_if.req_addr  = addr;
        for (int j = 0; j <= B_TOTAL; j++) begin
            @(negedge clk);
            if (j == 0) b_if.req_valid = 1'b0;
            exp_addr = 1'b0;
            if (j < 4) exp_addr = addr[j];
            exp_vld = (j == B_TOTAL);
            n_tests += 3;
            if (b_if.addr_stream !== exp_addr) begin
                n_fail++;
                $display("FAIL lsb addr_stream c%0d: got %b want %b", j, b_if.addr_stream, exp_addr);
            end
            if (b_if.rsp_valid !== exp_vld) begin
                n_fail++;
                $display("FAIL lsb rsp_valid c%0d: got %b want %b", j, b_if.rsp_valid, exp_vld);
            end
            if (b_if.fetch_active !== (j < B_TOTAL)) begin
                n_fail++;
                $display("FAIL lsb active c%0d: got %b want %b", j, b_if.fetch_active, (j < B_TOTAL));
            end
            b_if.data_stream = (j >= 5 && j < 13) ? tbits[j-5] : 1'b0;
        end
        n_tests++;
        if (b_if.rsp_data !== 8'h81) begin
            n_fail++;
            $display("FAIL lsb rsp_data: got %h want 81", b_if.rsp_data);
        end
        $display("[TB] lsb_first: addr %h -> data %h", addr, b_if.rsp_data);
    endtask

    task automatic test_no_turnaround();
        logic [7:0] addr, word;
        logic       exp_addr, exp_vld;
        addr = 8'h3C;
        word = 8'h96;
        @(negedge clk);
        c_if.req_valid = 1'b1;
        c_if.req_addr  = addr;
        for (int j = 0; j <= C_TOTAL; j++) begin
            @(negedge clk);
            if (j == 0) c_if.req_valid = 1'b0;
            exp_addr = 1'b0;
            if (j < 8) exp_addr = addr[7-j];
            exp_vld = (j == C_TOTAL);
            n_tests += 3;
            if (c_if.addr_stream !== exp_addr) begin
                n_fail++;
                $display("FAIL noturn addr_stream c%0d: got %b want %b", j, c_if.addr_stream, exp_addr);
            end
            if (c_if.rsp_valid !== exp_vld) begin
                n_fail++;
                $display("FAIL noturn rsp_valid c%0d: got %b want %b", j, c_if.rsp_valid, exp_vld);
            end
            if (c_if.fetch_active !== (j < C_TOTAL)) begin
                n_fail++;
                $display("FAIL noturn active c%0d: got %b want %b", j, c_if.fetch_active, (j < C_TOTAL));
            end
            c_if.data_stream = (j >= 8 && j < 16) ? word[7-(j-8)] : 1'b0;
        end
        n_tests++;
        if (c_if.rsp_data !== 8'h96) begin
            n_fail++;
            $display("FAIL noturn rsp_data: got %h want 96", c_if.rsp_data);
        end
        $display("[TB] no_turnaround: addr %h -> data %h", addr, c_if.rsp_data);
    endtask

    task automatic test_abort();
        // 5th RECV cycle: 8 address cycles + 1 turnaround + 4
        fetch_a(8'h11, 32'hCAFEF00D, 13, 1'b0, 8'h00, 1'b0, "abort_recv");
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            n_tests++;
            if (a_if.rsp_valid !== 1'b0 || a_if.rsp_data !== 32'hDEADBEEF) begin
                n_fail++;
                $display("FAIL abort quiet c%0d: got %b/%h want 0/deadbeef", i, a_if.rsp_valid, a_if.rsp_data);
            end
        end
        fetch_a(8'h22, 32'h0F1E2D3C, -1, 1'b0, 8'h00, 1'b0, "after_abort");
        fetch_a(8'h80, 32'h55AA33CC, A_TOTAL, 1'b0, 8'h00, 1'b0, "abort_done");
    endtask

    task automatic test_reset_mid_fetch();
        @(negedge clk);
        a_if.req_valid = 1'b1;
        a_if.req_addr  = 8'hFF;
        repeat (3) @(negedge clk);
        n_tests++;
        if (a_if.addr_stream !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst pre addr_stream: got %b want 1", a_if.addr_stream);
        end
        rst_n = 1'b0;
        #1;
        n_tests += 5;
        if (a_if.req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst ready: got %b want 1", a_if.req_ready); end
        if (a_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst rsp_valid: got %b want 0", a_if.rsp_valid); end
        if (a_if.rsp_data !== 32'h0) begin n_fail++; $display("FAIL midrst rsp_data: got %h want 0", a_if.rsp_data); end
        if (a_if.addr_stream !== 1'b0) begin n_fail++; $display("FAIL midrst addr_stream: got %b want 0", a_if.addr_stream); end
        if (a_if.fetch_active !== 1'b0) begin n_fail++; $display("FAIL midrst active: got %b want 0", a_if.fetch_active); end
        a_prev = 32'h0;
        $display("[TB] reset_mid_fetch: outputs cleared");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        a_if.req_addr = 8'h5A;
        // req_valid is still high: accept must happen on the first edge after release
        fetch_a(8'h5A, 32'h12345678, -1, 1'b1, 8'hC3, 1'b1, "post_reset");
    endtask

    task automatic test_back_to_back();
        fetch_a(8'hC3, 32'h87654321, -1, 1'b0, 8'h00, 1'b0, "back_to_back");
    endtask

    initial begin
        a_if.req_valid = 1'b0; a_if.req_addr = '0; a_if.abort = 1'b0; a_if.data_stream = 1'b0;
        b_if.req_valid = 1'b0; b_if.req_addr = '0; b_if.abort = 1'b0; b_if.data_stream = 1'b0;
        c_if.req_valid = 1'b0; c_if.req_addr = '0; c_if.abort = 1'b0; c_if.data_stream = 1'b0;
        test_reset();
        test_default_fetch();
        test_lsb_first();
        test_no_turnaround();
        test_abort();
        test_reset_mid_fetch();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_fetch_engine.md
SERIAL_FETCH_ENGINE -- requirements
Module: serial_fetch_engine

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: address bits serialised per fetch (2..32).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data bits deserialised per fetch (2..64).
REQ-003 SHALL have parameter TURNAROUND, default 1: idle cycles between last address bit and first data bit (0..15).
REQ-004 SHALL have parameter LSB_FIRST, default 0: 0 = MSB-first on both streams, 1 = LSB-first on both streams.
REQ-005 SHALL have port sys_clk, input, 1: sole clock; all state changes on rising edge.
REQ-006 SHALL have port sys_reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port req_valid, input, 1: fetch request present.
REQ-008 SHALL have port req_addr, input, ADDR_WIDTH: fetch address, sampled on accept.
REQ-009 SHALL have port req_ready, output, 1: engine can accept a request.
REQ-010 SHALL have port abort, input, 1: synchronous cancel of the fetch in progress.
REQ-011 SHALL have port addr_stream, output, 1: serial address bit to external memory.
REQ-012 SHALL have port data_stream, input, 1: serial data bit from external memory.
REQ-013 SHALL have port fetch_active, output, 1: high in SEND_ADDR, TURN and RECV.
REQ-014 SHALL have port rsp_valid, output, 1: one-cycle pulse, fetch complete.
REQ-015 SHALL have port rsp_data, output, DATA_WIDTH: assembled data word.

Function
REQ-016 SHALL implement states IDLE, SEND_ADDR, TURN, RECV, DONE.
REQ-017 req_ready SHALL be 1 only in IDLE; accept = req_valid & req_ready at a rising edge, which latches req_addr and moves to SEND_ADDR.
REQ-018 req_valid outside IDLE SHALL be ignored, with no queuing.
REQ-019 SEND_ADDR SHALL last exactly ADDR_WIDTH cycles; addr_stream SHALL present latched address bit k in the k-th cycle, in the order set by LSB_FIRST.
REQ-020 addr_stream SHALL be 0 in every state other than SEND_ADDR.
REQ-021 After SEND_ADDR, the engine SHALL enter TURN for TURNAROUND cycles; when TURNAROUND=0 it SHALL go directly to RECV.
REQ-022 RECV SHALL last exactly DATA_WIDTH cycles, sampling data_stream at the closing edge of each cycle.
REQ-023 In RECV, MSB-first SHALL shift left, inserting at bit 0; LSB-first SHALL shift right, inserting at bit DATA_WIDTH-1.
REQ-024 DONE SHALL last one cycle with rsp_valid=1 and the complete word on rsp_data, then return to IDLE.
REQ-025 Latency SHALL be fixed: rsp_valid is high in the cycle beginning ADDR_WIDTH+TURNAROUND+DATA_WIDTH edges after the accept edge.
REQ-026 rsp_data SHALL hold its value until the next DONE; partial words SHALL NOT be visible on rsp_data.
REQ-027 abort=1 in SEND_ADDR, TURN or RECV SHALL return the engine to IDLE at the next edge, with no rsp_valid and rsp_data unchanged.
REQ-028 abort in IDLE or DONE SHALL have no effect; DONE still completes.
REQ-029 Bit counters SHALL be sized clog2 of the relevant width, with a minimum of 1 bit, and SHALL NOT wrap within a phase.

Reset
REQ-030 sys_reset_n=0 SHALL immediately set: state IDLE, req_ready=1, rsp_valid=0, rsp_data=0, addr_stream=0, fetch_active=0, counters and latched address cleared.
REQ-031 Reset asserted mid-fetch SHALL discard the fetch, with no rsp_valid after release.
REQ-032 The first accept SHALL be possible at the first rising edge after sys_reset_n deasserts.

Verification
REQ-033 Defaults, req_addr=0xA5, data_stream driven 0xDEADBEEF MSB-first -> addr_stream 1,0,1,0,0,1,0,1; rsp_valid 41 edges after accept; rsp_data=0xDEADBEEF.
REQ-034 LSB_FIRST=1, ADDR_WIDTH=4, DATA_WIDTH=8, req_addr=0x3, data bits 1,0,0,0,0,0,0,1 in time order -> addr_stream 1,1,0,0; rsp_data=0x81.
REQ-035 TURNAROUND=0, ADDR_WIDTH=8, DATA_WIDTH=8 -> first data sample on the edge closing the cycle right after the last address bit; rsp_valid 16 edges after accept.
REQ-036 abort pulsed in the 5th RECV cycle -> IDLE next edge; no rsp_valid; rsp_data keeps its prior value; next request completes normally.
REQ-037 sys_reset_n pulsed low mid-SEND_ADDR -> all outputs at reset values immediately; req_valid held high while busy is never accepted until IDLE.
